ysyx_24110015_lsu: RTL and testbench
====================================

YSYX_24110015_LSU -- requirements
Module: ysyx_24110015_LSU

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (REQ/WAIT combined).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  upstream (EXU) operation valid.
REQ-005 in_ready  out  1  LSU can accept an operation.
REQ-006 addr  in  32  ALU result: memory address, or pass-through result for non-memory ops.
REQ-007 wdata  in  32  store data (rs2), unaligned in bits [7:0]/[15:0]/[31:0].
REQ-008 MemWrite, MemRead  in  1 each  access type.
REQ-009 MemOp  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 out_valid / out_ready  out / in  1 each  result handshake to writeback.
REQ-011 data_out  out  32  result; err  out  1  access fault (misaligned, illegal MemOp, timeout).
REQ-012 req_valid/req_ready  out/in  1  bus request handshake; req_wen out 1; req_addr out 32 (word-aligned, addr & ~3); req_wdata out 32; req_wmask out 4.
REQ-013 resp_valid  in  1; resp_rdata  in  32  full word read from req_addr.

Function
REQ-014 FSM states IDLE, REQ, WAIT, DONE; in_ready SHALL equal (state==IDLE).
REQ-015 Acceptance = in_valid & in_ready; inputs SHALL be registered on acceptance and held stable internally thereafter.
REQ-016 Accepted op with neither MemRead nor MemWrite: IDLE->DONE, data_out=addr, err=0; out_valid asserted the next cycle.
REQ-017 MemWrite and MemRead both set: treated as a store.
REQ-018 Misaligned (h/hu with addr[0]=1; w with addr[1:0]!=0) or illegal MemOp (011,110,111; 100/101 for stores): IDLE->DONE, no bus request, data_out=0, err=1.
REQ-019 Legal access: IDLE->REQ; req_valid=1 in REQ with all req_* stable until req_valid&req_ready, then ->WAIT.
REQ-020 Store lanes: byte mask 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; req_wdata = wdata shifted left by 8*addr[1:0]; loads drive req_wmask=0000, req_wen=0.
REQ-021 resp_valid SHALL be sampled only in WAIT; on it ->DONE; ignored in IDLE/REQ/DONE.
REQ-022 Load result: word = resp_rdata >> 8*addr[1:0]; b/h sign-extend bit 7/15, bu/hu zero-extend; store result data_out=0, err=0.
REQ-023 Watchdog counter cleared on entering REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES ->DONE with data_out=0, err=1, req_valid deasserted.
REQ-024 DONE: out_valid=1, data_out/err stable until out_ready; then ->IDLE (no same-cycle re-acceptance; minimum 2 cycles per op).
REQ-025 Minimum latency acceptance->out_valid: 1 cycle non-memory/fault; 3 cycles for a bus access with req_ready=1 and resp_valid one cycle later.

Reset
REQ-026 On rst: state=IDLE, out_valid=0, data_out=0, err=0, req_valid=0, req_wen=0, req_wmask=0, watchdog=0.
REQ-027 rst mid-operation SHALL abandon the access; a response arriving after reset SHALL be ignored.

Structure
REQ-028 Shared package: MemOp code constants, FSM state enum, lane-mask constants.
REQ-029 One sub-module ysyx_24110015_LSU_align: combinational store lane shift/mask and load shift/extend.

Verification
REQ-030 Non-mem op addr=0x12345678 -> next cycle out_valid=1, data_out=0x12345678, no req_valid.
REQ-031 lb addr=0x80000003, resp_rdata=0x80FF0000 -> req_addr=0x80000000, data_out=0xFFFFFF80; lbu -> 0x00000080.
REQ-032 sh addr=0x80000002, wdata=0x0000ABCD -> req_wmask=1100, req_wdata=0xABCD0000, data_out=0, err=0.
REQ-033 lw addr=0x80000002 -> no bus request, out_valid next cycle, err=1, data_out=0.
REQ-034 req_ready held 0 for 3 cycles, then resp delayed 2 cycles; out_ready held 0 for 4 cycles -> req_* stable, data_out stable, single completion.
REQ-035 TIMEOUT_CYCLES=8, resp_valid never -> err=1 at cycle 8; rst asserted in WAIT then late resp_valid -> stays IDLE, out_valid=0.

Source files
------------

// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the MemOp encodings, the FSM state enum, the store lane masks and
// the legality check that sorts an operation into bus access or access fault.
package ysyx_24110015_lsu_pkg;

    // MemOp encodings
    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    // Byte-lane masks before shifting by the address offset
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // True when the access is a legal, naturally aligned op for its direction.
    function automatic logic access_ok(input logic [2:0] op, input logic [1:0] off,
                                       input logic is_store);
        logic ok;
        ok = 1'b0;
        case (op)
            MEMOP_B:  ok = 1'b1;
            MEMOP_H:  ok = ~off[0];
            MEMOP_W:  ok = (off == 2'b00);
            MEMOP_BU: ok = ~is_store;
            MEMOP_HU: ok = ~is_store & ~off[0];
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Combinational lane steering for the LSU.
// Store side: shifts store data into its byte lanes and builds the write mask.
// Load side: shifts the returned word down by the byte offset and extends.
// Ports: st_op/st_off/wdata -> st_wdata_c/st_wmask_c;
//        ld_op/ld_off/rdata -> ld_data_c.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
(
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [31:0] st_wdata_c,
    output logic [3:0]  st_wmask_c,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data_c
);

    logic [31:0] shifted;

    // Store lanes: data and mask move up by the byte offset
    always_comb begin
        st_wdata_c = wdata << {st_off, 3'b000};
        st_wmask_c = MASK_NONE;
        case (st_op)
            MEMOP_B: st_wmask_c = MASK_B << st_off;
            MEMOP_H: st_wmask_c = MASK_H << st_off;
            MEMOP_W: st_wmask_c = MASK_W;
            default: st_wmask_c = MASK_NONE;
        endcase
    end

    // Load extract: shift the addressed byte down to lane 0, then extend
    always_comb begin
        shifted   = rdata >> {ld_off, 3'b000};
        ld_data_c = 32'h0;
        case (ld_op)
            MEMOP_B:  ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_H:  ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_W:  ld_data_c = shifted;
            MEMOP_BU: ld_data_c = {24'h0, shifted[7:0]};
            MEMOP_HU: ld_data_c = {16'h0, shifted[15:0]};
            default:  ld_data_c = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: accepts one op from EXU, issues at most one bus access,
// and returns the result to writeback.
// Ports: clk/rst; in_valid/in_ready + addr/wdata/MemWrite/MemRead/MemOp from EXU;
//        out_valid/out_ready + data_out/err to writeback;
//        req_* bus request channel, resp_valid/resp_rdata bus response.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  MemOp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_wen,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wmask,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state;
    logic [WD_W-1:0] wd;
    logic [1:0]      off_q;
    logic [2:0]      memop_q;
    logic            store_q;

    logic [31:0] st_wdata_c;
    logic [3:0]  st_wmask_c;
    logic [31:0] ld_data_c;

    assign in_ready = (state == S_IDLE);

    // Store lanes come from the live inputs so req_* are ready the cycle after
    // acceptance; load extraction uses the held offset/op.
    ysyx_24110015_lsu_align u_align (
        .st_op      (MemOp),
        .st_off     (addr[1:0]),
        .wdata      (wdata),
        .st_wdata_c (st_wdata_c),
        .st_wmask_c (st_wmask_c),
        .ld_op      (memop_q),
        .ld_off     (off_q),
        .rdata      (resp_rdata),
        .ld_data_c  (ld_data_c)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            data_out  <= 32'h0;
            err       <= 1'b0;
            req_valid <= 1'b0;
            req_wen   <= 1'b0;
            req_wmask <= MASK_NONE;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            wd        <= '0;
            off_q     <= 2'b00;
            memop_q   <= 3'b000;
            store_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        off_q   <= addr[1:0];
                        memop_q <= MemOp;
                        store_q <= MemWrite;
                        if (!MemRead && !MemWrite) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            data_out  <= addr;
                            err       <= 1'b0;
                        end else if (!access_ok(MemOp, addr[1:0], MemWrite)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            data_out  <= 32'h0;
                            err       <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            req_valid <= 1'b1;
                            req_wen   <= MemWrite;
                            req_addr  <= {addr[31:2], 2'b00};
                            req_wdata <= st_wdata_c;
                            req_wmask <= MemWrite ? st_wmask_c : MASK_NONE;
                            wd        <= '0;
                        end
                    end
                end
                // Watchdog wins over a same-cycle handshake so the bound always holds
                S_REQ: begin
                    if (wd == WD_LAST) begin
                        state     <= S_DONE;
                        req_valid <= 1'b0;
                        out_valid <= 1'b1;
                        data_out  <= 32'h0;
                        err       <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                        if (req_ready) begin
                            state     <= S_WAIT;
                            req_valid <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wd == WD_LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        data_out  <= 32'h0;
                        err       <= 1'b1;
                    end else if (resp_valid) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        data_out  <= store_q ? 32'h0 : ld_data_c;
                        err       <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Self-checking bench for ysyx_24110015_lsu: directed cases plus randomized
// ops checked against a byte-arithmetic reference model.
module tb_ysyx_24110015_lsu;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  MemOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        err;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_24110015_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr       (addr),
        .wdata      (wdata),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemOp      (MemOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err        (err),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: size in bytes, offset within word, plain integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] wd_in,
                                  input logic mr, input logic mw, input logic [2:0] op,
                                  input logic [31:0] rd, output bit bus,
                                  output logic exp_err, output logic [31:0] dout,
                                  output logic [3:0] mask, output logic [31:0] wdo);
        int off;
        int size;
        bit legal;
        longint v;
        longint lim;
        off = int'(a % 32'd4);
        bus = 0; exp_err = 1'b0; dout = 32'h0; mask = 4'h0; wdo = 32'h0;
        if (!mr && !mw) begin
            dout = a;
            return;
        end
        case (op)
            3'd0, 3'd1, 3'd2: legal = 1;
            3'd4, 3'd5:       legal = !mw;
            default:          legal = 0;
        endcase
        size = 1 << int'(op[1:0]);
        if (!legal || (off % size) != 0) begin
            exp_err = 1'b1;
            return;
        end
        bus = 1;
        if (mw) begin
            mask = 4'(((1 << size) - 1) << off);
            wdo  = 32'(longint'(wd_in) << (8 * off));
            return;
        end
        lim = longint'(1) << (8 * size);
        v   = (longint'(rd) >> (8 * off)) & (lim - 1);
        if (op < 3'd4 && size < 4 && v >= lim / 2) v -= lim;
        dout = 32'(v);
    endfunction

    // One complete operation with a scripted bus and writeback back-pressure.
    task automatic do_op(input logic [31:0] a, input logic [31:0] wd_in, input logic mr,
                         input logic mw, input logic [2:0] op, input logic [31:0] rd,
                         input int rq_dly, input int rs_dly, input int out_dly);
        bit          bus;
        logic        e_err;
        logic [31:0] e_dout;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        model(a, wd_in, mr, mw, op, rd, bus, e_err, e_dout, e_mask, e_wdata);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        addr = a; wdata = wd_in; MemRead = mr; MemWrite = mw; MemOp = op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        addr = $urandom; wdata = $urandom; MemOp = 3'($urandom);
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        if (bus) begin
            for (int i = 0; i <= rq_dly; i++) begin
                @(negedge clk);
                chk("req_valid", 32'(req_valid), 32'd1);
                chk("req_addr", req_addr, {a[31:2], 2'b00});
                chk("req_wen", 32'(req_wen), 32'(mw));
                chk("req_wmask", 32'(req_wmask), 32'(e_mask));
                if (mw) chk("req_wdata", req_wdata, e_wdata);
                chk("out_valid_req", 32'(out_valid), 32'd0);
                req_ready  = (i == rq_dly);
                resp_valid = 1'($urandom);
                resp_rdata = $urandom;
            end
            @(posedge clk);
            #1 req_ready = 1'b0;
            for (int i = 0; i <= rs_dly; i++) begin
                @(negedge clk);
                chk("req_valid_wait", 32'(req_valid), 32'd0);
                chk("out_valid_wait", 32'(out_valid), 32'd0);
                resp_valid = (i == rs_dly);
                resp_rdata = (i == rs_dly) ? rd : $urandom;
            end
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
            resp_rdata = $urandom;
        end
        for (int i = 0; i <= out_dly; i++) begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("data_out", data_out, e_dout);
            chk("err", 32'(err), 32'(e_err));
            chk("req_valid_done", 32'(req_valid), 32'd0);
            out_ready = (i == out_dly);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int done_at;
        rst = 1'b1; in_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
        MemWrite = 1'b0; MemRead = 1'b0; MemOp = 3'b000; out_ready = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_wen", 32'(req_wen), 32'd0);
        chk("rst_req_wmask", 32'(req_wmask), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        do_op(32'h12345678, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 0, 0, 0);          // pass-through
        do_op(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF0000, 0, 0, 0);   // lb
        do_op(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF0000, 0, 0, 0);   // lbu
        do_op(32'h80000002, 32'h0000ABCD, 1'b0, 1'b1, 3'b001, 32'h0, 0, 0, 0);   // sh
        do_op(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 0, 0, 0);          // misaligned lw
        do_op(32'h80000001, 32'h0, 1'b1, 1'b0, 3'b101, 32'h0, 0, 0, 0);          // misaligned lhu
        do_op(32'h80000000, 32'h11, 1'b0, 1'b1, 3'b100, 32'h0, 0, 0, 0);         // store with bu: illegal
        do_op(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 0, 0, 0);          // op 011: illegal
        do_op(32'h80000004, 32'hDEADBEEF, 1'b1, 1'b1, 3'b010, 32'h0, 0, 0, 0);   // both set: store
        do_op(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b001, 32'h8001_7FFF, 0, 0, 0);  // lh upper half
        do_op(32'h80000008, 32'h0, 1'b1, 1'b0, 3'b010, 32'hCAFEF00D, 3, 2, 4);   // back-pressure

        // Randomized ops; bus delays stay well inside the watchdog
        for (int n = 0; n < 40; n++) begin
            do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom), $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Watchdog: request accepted, response never arrives
        @(negedge clk);
        addr = 32'h80000010; MemRead = 1'b1; MemWrite = 1'b0; MemOp = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        done_at = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            req_ready = (n == 1);
            if (out_valid) begin
                done_at = n;
                break;
            end
        end
        req_ready = 1'b0;
        chk("timeout_cycle", 32'(done_at), 32'(TMO + 1));
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_data", data_out, 32'h0);
        chk("timeout_req_valid", 32'(req_valid), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset while waiting for a response, then a stale response
        @(negedge clk);
        addr = 32'h80000020; MemRead = 1'b1; MemWrite = 1'b0; MemOp = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_req_valid", 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_req_valid0", 32'(req_valid), 32'd0);
        resp_valid = 1'b1; resp_rdata = 32'h5555AAAA;
        @(negedge clk);
        resp_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("late_resp_out_valid", 32'(out_valid), 32'd0);
            chk("late_resp_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
